// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage: pipeline memory-access stage. Drives data-SRAM stores, extracts |
// | loads, forwards to ID/EX. Option macro: MS_UNALIGNED_CHK_EN (adds ms_ale). |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 107,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [32:0]                ms_to_es_forward_bus,
  output logic [37:0]                ms_to_ds_forward_bus,
  output logic [5:0]                 ms_to_hazard_bus,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_wdata,
  input  logic [31:0]                data_sram_rdata
`ifdef MS_UNALIGNED_CHK_EN
  ,
  output logic                       ms_ale
`endif
);

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  logic                       st_done_q, st_done_d;
  logic                       ld_hold_valid_q, ld_hold_valid_d;
  logic [31:0]                ld_hold_data_q, ld_hold_data_d;

  logic        res_from_mem, gr_we, mem_we, unsigned_ext_ld;
  logic [4:0]  dest;
  logic [1:0]  st_size, addr;
  logic [31:0] alu_result, rkd_value, pc;
  logic        ms_latch, store_active, store_en, wb_gr_we;
  logic [31:0] mem_data, ld_word, final_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign res_from_mem    = bus_q[106];
  assign gr_we           = bus_q[105];
  assign mem_we          = bus_q[104];
  assign dest            = bus_q[103:99];
  assign unsigned_ext_ld = bus_q[98];
  assign st_size         = bus_q[97:96];
  assign alu_result      = bus_q[95:64];
  assign rkd_value       = bus_q[63:32];
  assign pc              = bus_q[31:0];
  assign addr            = alu_result[1:0];

  assign ms_allowin     = !ms_valid_q || ws_allowin;
  assign ms_to_ws_valid = ms_valid_q;
  assign ms_latch       = es_to_ms_valid && ms_allowin && !ms_flush;
  assign store_active   = ms_valid_q && mem_we && !st_done_q;

`ifdef MS_UNALIGNED_CHK_EN
  logic misaligned;
  assign misaligned = ((st_size == 2'd1) && addr[0]) || (st_size[1] && (addr != 2'd0));
  assign ms_ale     = ms_valid_q && (mem_we || res_from_mem) && misaligned;
  assign store_en   = store_active && !misaligned;
  assign wb_gr_we   = gr_we && !(res_from_mem && misaligned);
`else
  assign store_en   = store_active;
  assign wb_gr_we   = gr_we;
`endif

  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = rkd_value;
    unique case (st_size)
      2'd0: begin
        data_sram_wdata = {4{rkd_value[7:0]}};
        if (store_en) data_sram_we = 4'b0001 << addr;
      end
      2'd1: begin
        data_sram_wdata = {2{rkd_value[15:0]}};
        if (store_en) data_sram_we = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (store_en) data_sram_we = 4'b1111;
      end
    endcase
  end

  // Data held from the first MEM cycle wins once the SRAM output has moved on.
  always_comb begin
    mem_data = ld_hold_valid_q ? ld_hold_data_q : data_sram_rdata;
    unique case (addr)
      2'd0:    ld_byte = mem_data[7:0];
      2'd1:    ld_byte = mem_data[15:8];
      2'd2:    ld_byte = mem_data[23:16];
      default: ld_byte = mem_data[31:24];
    endcase
    ld_half = addr[1] ? mem_data[31:16] : mem_data[15:0];
    unique case (st_size)
      2'd0:    ld_word = {{24{ld_byte[7] & !unsigned_ext_ld}}, ld_byte};
      2'd1:    ld_word = {{16{ld_half[15] & !unsigned_ext_ld}}, ld_half};
      default: ld_word = mem_data;
    endcase
    final_result = res_from_mem ? ld_word : alu_result;
  end

  assign ms_to_ws_bus = {wb_gr_we, dest, final_result, pc};

  always_comb begin
    ms_to_es_forward_bus = 33'd0;
    ms_to_ds_forward_bus = 38'd0;
    ms_to_hazard_bus     = 6'd0;
    if (ms_valid_q) begin
      ms_to_es_forward_bus = {store_active, alu_result};
      ms_to_ds_forward_bus = {wb_gr_we && (dest != 5'd0), dest, final_result};
      ms_to_hazard_bus     = {dest, res_from_mem};
    end
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (ms_flush)        ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    bus_d = ms_latch ? es_to_ms_bus : bus_q;

    st_done_d = st_done_q;
    if (ms_latch)          st_done_d = 1'b0;
    else if (store_active) st_done_d = 1'b1;

    ld_hold_valid_d = ld_hold_valid_q;
    ld_hold_data_d  = ld_hold_data_q;
    if (ms_latch || ms_flush || !ms_valid_q) begin
      ld_hold_valid_d = 1'b0;
    end else if (!ld_hold_valid_q && !ws_allowin) begin
      ld_hold_valid_d = 1'b1;
      ld_hold_data_d  = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q      <= 1'b0;
      bus_q           <= '0;
      st_done_q       <= 1'b0;
      ld_hold_valid_q <= 1'b0;
      ld_hold_data_q  <= 32'd0;
    end else begin
      ms_valid_q      <= ms_valid_d;
      bus_q           <= bus_d;
      st_done_q       <= st_done_d;
      ld_hold_valid_q <= ld_hold_valid_d;
      ld_hold_data_q  <= ld_hold_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage: directed self-checking bench for mem_stage with a WB-bus     |
// | scoreboard. Honours MS_UNALIGNED_CHK_EN. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

  logic         clk, reset, ms_flush, ws_allowin, ms_allowin;
  logic         es_to_ms_valid, ms_to_ws_valid;
  logic [106:0] es_to_ms_bus;
  logic [69:0]  ms_to_ws_bus;
  logic [32:0]  ms_to_es_forward_bus;
  logic [37:0]  ms_to_ds_forward_bus;
  logic [5:0]   ms_to_hazard_bus;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_wdata, data_sram_rdata;
`ifdef MS_UNALIGNED_CHK_EN
  logic         ms_ale;
`endif

  int total = 0;
  int bad   = 0;
  logic [69:0] sb[$];
  logic [69:0] exp_wb;

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .ms_flush             (ms_flush),
    .ws_allowin           (ws_allowin),
    .ms_allowin           (ms_allowin),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .ms_to_ws_valid       (ms_to_ws_valid),
    .ms_to_ws_bus         (ms_to_ws_bus),
    .ms_to_es_forward_bus (ms_to_es_forward_bus),
    .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
    .ms_to_hazard_bus     (ms_to_hazard_bus),
    .data_sram_we         (data_sram_we),
    .data_sram_wdata      (data_sram_wdata),
    .data_sram_rdata      (data_sram_rdata)
`ifdef MS_UNALIGNED_CHK_EN
    ,
    .ms_ale               (ms_ale)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [106:0] mk(input logic rfm, input logic gw, input logic mw,
                                      input logic [4:0] dst, input logic uns,
                                      input logic [1:0] sz, input logic [31:0] alu,
                                      input logic [31:0] rkd, input logic [31:0] pcv);
    return {rfm, gw, mw, dst, uns, sz, alu, rkd, pcv};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [106:0] b, input logic push, input logic [69:0] wb);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    if (push) sb.push_back(wb);
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  // WB handshake monitor: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL wb_unexpected observed=%h expected=empty", ms_to_ws_bus);
      end else begin
        exp_wb = sb.pop_front();
        assert (ms_to_ws_bus === exp_wb) else begin
          bad++;
          $error("FAIL wb_bus observed=%h expected=%h", ms_to_ws_bus, exp_wb);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; ms_flush = 1'b0; ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_sram_rdata = 32'd0;
    tick(); tick();
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_ws_valid", ms_to_ws_valid, 0);
    chk("rst_we", data_sram_we, 0);
    chk("rst_wdata", data_sram_wdata, 0);
    chk("rst_es_fwd", ms_to_es_forward_bus, 0);
    chk("rst_ds_fwd", ms_to_ds_forward_bus, 0);
    chk("rst_hazard", ms_to_hazard_bus, 0);
    reset = 1'b0;
    tick();

    // ld.b signed / unsigned at byte 3
    issue(mk(1, 1, 0, 5'd5, 0, 2'd0, 32'h1003, 0, 32'h100), 1, {1'b1, 5'd5, 32'hFFFF_FF80, 32'h100});
    data_sram_rdata = 32'h80FF_1234;
    #1;
    chk("ldb_hazard", ms_to_hazard_bus, {5'd5, 1'b1});
    chk("ldb_ds_fwd", ms_to_ds_forward_bus, {1'b1, 5'd5, 32'hFFFF_FF80});
    tick();
    issue(mk(1, 1, 0, 5'd6, 1, 2'd0, 32'h1003, 0, 32'h104), 1, {1'b1, 5'd6, 32'h0000_0080, 32'h104});
    #1;
    chk("ldbu_ds_fwd", ms_to_ds_forward_bus, {1'b1, 5'd6, 32'h0000_0080});
    tick();

    // st.b at offset 1
    data_sram_rdata = 32'd0;
    issue(mk(0, 0, 1, 5'd0, 0, 2'd0, 32'h1001, 32'h0000_00AB, 32'h108), 1, {1'b0, 5'd0, 32'h1001, 32'h108});
    #1;
    chk("stb_we", data_sram_we, 4'b0010);
    chk("stb_wdata", data_sram_wdata, 32'hABAB_ABAB);
    tick();

    // st.h under a 3-cycle WB stall
    issue(mk(0, 0, 1, 5'd0, 0, 2'd1, 32'h2002, 32'h0000_BEEF, 32'h10C), 1, {1'b0, 5'd0, 32'h2002, 32'h10C});
    ws_allowin = 1'b0;
    #1;
    chk("sth_we_c1", data_sram_we, 4'b1100);
    chk("sth_wdata", data_sram_wdata, 32'hBEEF_BEEF);
    chk("sth_active_c1", ms_to_es_forward_bus, {1'b1, 32'h2002});
    chk("sth_allowin_c1", ms_allowin, 0);
    tick();
    chk("sth_we_c2", data_sram_we, 0);
    chk("sth_active_c2", ms_to_es_forward_bus, {1'b0, 32'h2002});
    chk("sth_allowin_c2", ms_allowin, 0);
    tick();
    chk("sth_we_c3", data_sram_we, 0);
    ws_allowin = 1'b1;
    #1;
    chk("sth_allowin_rel", ms_allowin, 1);
    chk("sth_we_rel", data_sram_we, 0);
    tick();

    // ld.w held across a stall while rdata changes
    issue(mk(1, 1, 0, 5'd7, 0, 2'd2, 32'h3000, 0, 32'h200), 1, {1'b1, 5'd7, 32'hCAFE_F00D, 32'h200});
    ws_allowin = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("ldw_c1", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    tick();
    data_sram_rdata = 32'd0;
    #1;
    chk("ldw_hold_c2", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    tick();
    chk("ldw_hold_c3", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    ws_allowin = 1'b1;
    #1;
    tick();

    // ld.h at address 3: upper half used; misalignment-checked build suppresses the write-back
`ifdef MS_UNALIGNED_CHK_EN
    issue(mk(1, 1, 0, 5'd9, 0, 2'd1, 32'h3, 0, 32'h300), 1, {1'b0, 5'd9, 32'hFFFF_8001, 32'h300});
    data_sram_rdata = 32'h8001_0000;
    #1;
    chk("ldh_ale", ms_ale, 1);
    chk("ldh_fwd_en", ms_to_ds_forward_bus[37], 0);
`else
    issue(mk(1, 1, 0, 5'd9, 0, 2'd1, 32'h3, 0, 32'h300), 1, {1'b1, 5'd9, 32'hFFFF_8001, 32'h300});
    data_sram_rdata = 32'h8001_0000;
    #1;
    chk("ldh_fwd", ms_to_ds_forward_bus, {1'b1, 5'd9, 32'hFFFF_8001});
`endif
    tick();
    data_sram_rdata = 32'd0;

    // st.w at 0x1001
    issue(mk(0, 0, 1, 5'd0, 0, 2'd2, 32'h1001, 32'h5555_AAAA, 32'h304), 1, {1'b0, 5'd0, 32'h1001, 32'h304});
    #1;
`ifdef MS_UNALIGNED_CHK_EN
    chk("stw_mis_ale", ms_ale, 1);
    chk("stw_mis_we", data_sram_we, 0);
`else
    chk("stw_mis_we", data_sram_we, 4'b1111);
    chk("stw_mis_wdata", data_sram_wdata, 32'h5555_AAAA);
`endif
    tick();

    // flush beats a simultaneous accept
    ms_flush = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 1, 1, 5'd3, 0, 2'd2, 32'h4000, 32'h1, 32'h400);
    #1;
    chk("flush_allowin", ms_allowin, 1);
    tick();
    ms_flush = 1'b0;
    es_to_ms_valid = 1'b0;
    #1;
    chk("flush_valid", ms_to_ws_valid, 0);
    chk("flush_we", data_sram_we, 0);
    chk("flush_fwd_en", ms_to_ds_forward_bus[37], 0);
    tick();

    // asynchronous reset in the middle of a word store
    issue(mk(0, 0, 1, 5'd0, 0, 2'd2, 32'h4000, 32'h1234_5678, 32'h500), 0, '0);
    #1;
    chk("rst_st_we", data_sram_we, 4'b1111);
    chk("rst_st_wdata", data_sram_wdata, 32'h1234_5678);
    chk("rst_st_es_fwd", ms_to_es_forward_bus, {1'b1, 32'h4000});
    reset = 1'b1;
    #1;
    chk("rst_async_we", data_sram_we, 0);
    chk("rst_async_valid", ms_to_ws_valid, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_rel_valid", ms_to_ws_valid, 0);
    chk("rst_rel_allowin", ms_allowin, 1);
    chk("rst_rel_hazard", ms_to_hazard_bus, 0);
    tick(); tick();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
